miniscope_seq: RTL and testbench

Sequencer for the miniscope FIFO RAM. It runs the circular write address and latches pre-trigger look-back start addresses into a small event queue. On request from the DMB readout sequencer it replays a fixed number of time bins from that RAM with a valid strobe, and it optionally accumulates RAM parity errors. It sits between the trigger/sequencer logic and the miniscope RAM block, driving that block's write enable, write address and read address.

---
 rtl/miniscope_seq_if.sv | 36 +++
 rtl/miniscope_seq.sv | 157 +++++++++++++++
 tb/tb_miniscope_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/miniscope_seq_if.sv
// Bus bundle between the trigger/readout controller, the miniscope RAM and miniscope_seq.
// master = controller/RAM side, slave = the sequencer.
interface miniscope_seq_if #(
  parameter int RAM_ADRB = 11,
  parameter int MXTBIN   = 5
);
  logic                mini_en;
  logic [MXTBIN-1:0]   mini_tbins_pre;
  logic [MXTBIN-1:0]   mini_tbins;
  logic                mini_trig;
  logic                mini_rd_start;
  logic [1:0]          parity_err_mini;
  logic                fifo_wen;
  logic [RAM_ADRB-1:0] fifo_wadr_mini;
  logic [RAM_ADRB-1:0] fifo_radr_mini;
  logic                mini_rd_busy;
  logic                mini_rd_valid;
  logic                mini_rd_done;
  logic                mini_q_empty;
  logic                mini_q_full;
  logic                mini_q_ovf;
  logic                mini_perr;
  logic [7:0]          mini_perr_cnt;

  modport master (
    output mini_en, mini_tbins_pre, mini_tbins, mini_trig, mini_rd_start, parity_err_mini,
    input  fifo_wen, fifo_wadr_mini, fifo_radr_mini, mini_rd_busy, mini_rd_valid,
           mini_rd_done, mini_q_empty, mini_q_full, mini_q_ovf, mini_perr, mini_perr_cnt
  );

  modport slave (
    input  mini_en, mini_tbins_pre, mini_tbins, mini_trig, mini_rd_start, parity_err_mini,
    output fifo_wen, fifo_wadr_mini, fifo_radr_mini, mini_rd_busy, mini_rd_valid,
           mini_rd_done, mini_q_empty, mini_q_full, mini_q_ovf, mini_perr, mini_perr_cnt
  );
endinterface

// File: rtl/miniscope_seq.sv
// Miniscope RAM sequencer: circular write address, trigger look-back queue, fixed-length replay.
// Optional parity error accounting is enabled by defining MINISCOPE_PARITY_CHECK_EN.
//
// state   | meaning
// S_IDLE  | waiting for mini_rd_start
// S_READ  | issuing one read address per cycle
// S_DRAIN | last RAM word in flight
// S_DONE  | one-cycle mini_rd_done pulse
module miniscope_seq #(
  parameter int RAM_ADRB = 11,
  parameter int MXTBIN   = 5,
  parameter int QDEPTH   = 4
) (
  input  logic           clock,
  input  logic           global_reset,
  miniscope_seq_if.slave bus
);

  localparam int QAW = $clog2(QDEPTH);

  localparam logic [RAM_ADRB-1:0] ADR_ONE   = RAM_ADRB'(1);
  localparam logic [MXTBIN-1:0]   TBIN_ONE  = MXTBIN'(1);
  localparam logic [QAW-1:0]      QPTR_ONE  = QAW'(1);
  localparam logic [QAW:0]        QCNT_ONE  = (QAW+1)'(1);
  localparam logic [QAW:0]        QCNT_FULL = (QAW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                wen_q;
  logic [RAM_ADRB-1:0] wadr_q, wadr_d;
  logic [RAM_ADRB-1:0] radr_q, radr_d;
  logic [MXTBIN-1:0]   tcnt_q, tcnt_d;
  logic                valid_q;
  logic                ovf_q, ovf_d;
  logic [RAM_ADRB-1:0] q_mem_q [QDEPTH];
  logic [QAW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [QAW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [QAW:0]        qcnt_q, qcnt_d;

  logic                q_empty, q_full, q_pop, push_ok;
  logic [RAM_ADRB-1:0] push_adr;

  assign q_empty  = (qcnt_q == '0);
  assign q_full   = (qcnt_q == QCNT_FULL);
  // A full queue still takes a push when the same cycle pops the head.
  assign push_ok  = bus.mini_trig && (!q_full || q_pop);
  assign push_adr = wadr_q - {{(RAM_ADRB-MXTBIN){1'b0}}, bus.mini_tbins_pre};
  assign wadr_d   = wen_q ? (wadr_q + ADR_ONE) : wadr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    qcnt_d   = qcnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + QPTR_ONE;
    if (q_pop)   rd_ptr_d = rd_ptr_q + QPTR_ONE;
    if (push_ok && !q_pop)      qcnt_d = qcnt_q + QCNT_ONE;
    else if (!push_ok && q_pop) qcnt_d = qcnt_q - QCNT_ONE;
    if (bus.mini_trig && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    radr_d  = radr_q;
    tcnt_d  = tcnt_q;
    q_pop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mini_rd_start) begin
          state_d = S_DONE;
          if (!q_empty) begin
            q_pop = 1'b1;
            if (bus.mini_tbins != '0) begin
              radr_d  = q_mem_q[rd_ptr_q];
              tcnt_d  = bus.mini_tbins;
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        radr_d = radr_q + ADR_ONE;
        tcnt_d = tcnt_q - TBIN_ONE;
        if (tcnt_q == TBIN_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      wadr_q   <= '0;
      radr_q   <= '0;
      tcnt_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      qcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wen_q    <= bus.mini_en;
      wadr_q   <= wadr_d;
      radr_q   <= radr_d;
      tcnt_q   <= tcnt_d;
      valid_q  <= (state_q == S_READ);
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qcnt_q   <= qcnt_d;
    end
  end

  // Entries are only meaningful between the pointers, so storage needs no reset.
  always_ff @(posedge clock) begin
    if (push_ok) q_mem_q[wr_ptr_q] <= push_adr;
  end

  assign bus.fifo_wen       = wen_q;
  assign bus.fifo_wadr_mini = wadr_q;
  assign bus.fifo_radr_mini = radr_q;
  assign bus.mini_rd_busy   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.mini_rd_valid  = valid_q;
  assign bus.mini_rd_done   = (state_q == S_DONE);
  assign bus.mini_q_empty   = q_empty;
  assign bus.mini_q_full    = q_full;
  assign bus.mini_q_ovf     = ovf_q;

`ifdef MINISCOPE_PARITY_CHECK_EN
  logic       perr_q;
  logic [7:0] perr_cnt_q;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      perr_q     <= 1'b0;
      perr_cnt_q <= '0;
    end else if (valid_q && (|bus.parity_err_mini)) begin
      perr_q <= 1'b1;
      if (perr_cnt_q != 8'hff) perr_cnt_q <= perr_cnt_q + 8'd1;
    end
  end

  assign bus.mini_perr     = perr_q;
  assign bus.mini_perr_cnt = perr_cnt_q;
`else
  logic unused_parity;
  assign unused_parity     = ^bus.parity_err_mini;
  assign bus.mini_perr     = 1'b0;
  assign bus.mini_perr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_miniscope_seq.sv
// Scoreboard bench for miniscope_seq: stimulus pushes expected read addresses and done cycles,
// a negedge monitor pops and compares them whenever the DUT strobes valid or done.
module tb_miniscope_seq;

  logic clock;
  logic global_reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [10:0] exp_adr_q [$];
  int          exp_done_q [$];
  logic [10:0] last_radr;

`ifdef MINISCOPE_PARITY_CHECK_EN
  localparam int EXP_PCNT = 3;
  localparam int EXP_PERR = 1;
`else
  localparam int EXP_PCNT = 0;
  localparam int EXP_PERR = 0;
`endif

  miniscope_seq_if #(.RAM_ADRB(11), .MXTBIN(5)) bus ();

  miniscope_seq #(.RAM_ADRB(11), .MXTBIN(5), .QDEPTH(4)) dut (
    .clock       (clock),
    .global_reset(global_reset),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (bus.mini_rd_valid) begin
      if (exp_adr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: got valid at addr %0d expected none (cycle %0d)", last_radr, cyc);
      end else begin
        check("rd_addr", 32'(last_radr), 32'(exp_adr_q.pop_front()));
      end
    end
    if (bus.mini_rd_done) begin
      if (exp_done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_done_unexpected: got done expected none (cycle %0d)", cyc);
      end else begin
        check("rd_done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
      end
    end
    last_radr = bus.fifo_radr_mini;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    step();
    step();
    global_reset = 1'b0;
  endtask

  task automatic trig(input int pre);
    bus.mini_trig      = 1'b1;
    bus.mini_tbins_pre = 5'(pre);
    step();
    bus.mini_trig = 1'b0;
  endtask

  // Issue mini_rd_start now; has_entry says whether the queue holds an event.
  task automatic do_read(input int start, input int n, input bit has_entry);
    int  t;
    int  span;
    bit  real_rd;
    real_rd = has_entry && (n > 0);
    bus.mini_rd_start = 1'b1;
    bus.mini_tbins    = 5'(n);
    t = cyc;
    if (real_rd) begin
      for (int i = 0; i < n; i++) exp_adr_q.push_back(11'((start + i) % 2048));
      exp_done_q.push_back(t + n + 2);
      span = n + 2;
    end else begin
      exp_done_q.push_back(t + 1);
      span = 1;
    end
    step();
    bus.mini_rd_start = 1'b0;
    bus.mini_trig     = 1'b0;
    for (int k = 1; k <= span; k++) begin
      @(negedge clock);
      check("rd_busy", 32'(bus.mini_rd_busy), 32'(real_rd && (k <= n + 1)));
      step();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.mini_en         = 1'b0;
    bus.mini_tbins_pre  = '0;
    bus.mini_tbins      = '0;
    bus.mini_trig       = 1'b0;
    bus.mini_rd_start   = 1'b0;
    bus.parity_err_mini = 2'b00;
    global_reset        = 1'b1;
    step();
    do_reset();

    // reset state
    @(negedge clock);
    check("rst_wen",      32'(bus.fifo_wen),       0);
    check("rst_wadr",     32'(bus.fifo_wadr_mini), 0);
    check("rst_radr",     32'(bus.fifo_radr_mini), 0);
    check("rst_busy",     32'(bus.mini_rd_busy),   0);
    check("rst_valid",    32'(bus.mini_rd_valid),  0);
    check("rst_done",     32'(bus.mini_rd_done),   0);
    check("rst_empty",    32'(bus.mini_q_empty),   1);
    check("rst_full",     32'(bus.mini_q_full),    0);
    check("rst_ovf",      32'(bus.mini_q_ovf),     0);
    check("rst_perr",     32'(bus.mini_perr),      0);
    check("rst_perr_cnt", 32'(bus.mini_perr_cnt),  0);
    step();

    // free-running write address, 2050 cycles through the wrap
    bus.mini_en = 1'b1;
    step();
    for (int k = 0; k < 2050; k++) begin
      @(negedge clock);
      check("wr_wen", 32'(bus.fifo_wen), 1);
      check("wr_wadr", 32'(bus.fifo_wadr_mini), 32'(k % 2048));
      step();
    end
    bus.mini_en = 1'b0;

    // look-back wrap: wadr=3, pre=7 -> start 2044
    do_reset();
    bus.mini_en = 1'b1;
    step();
    step();
    step();
    bus.mini_en = 1'b0;
    step();
    @(negedge clock);
    check("lb_wadr_hold", 32'(bus.fifo_wadr_mini), 3);
    step();
    trig(7);
    @(negedge clock);
    check("lb_not_empty", 32'(bus.mini_q_empty), 0);
    step();
    do_read(2044, 4, 1'b1);
    @(negedge clock);
    check("lb_empty_after", 32'(bus.mini_q_empty), 1);
    step();

    // queue fill, simultaneous push/pop on full, overflow, ordered drain
    do_reset();
    for (int i = 1; i <= 4; i++) trig(i);
    @(negedge clock);
    check("q_full_4", 32'(bus.mini_q_full), 1);
    check("q_ovf_4",  32'(bus.mini_q_ovf),  0);
    step();
    bus.mini_trig      = 1'b1;
    bus.mini_tbins_pre = 5'd10;
    do_read(2047, 1, 1'b1);
    @(negedge clock);
    check("q_full_pushpop", 32'(bus.mini_q_full), 1);
    check("q_ovf_pushpop",  32'(bus.mini_q_ovf),  0);
    step();
    trig(5);
    @(negedge clock);
    check("q_ovf_5th",  32'(bus.mini_q_ovf),  1);
    check("q_full_5th", 32'(bus.mini_q_full), 1);
    step();
    do_read(2046, 2, 1'b1);
    do_read(2045, 3, 1'b1);
    do_read(2044, 1, 1'b1);
    do_read(2038, 5, 1'b1);
    @(negedge clock);
    check("q_empty_drained", 32'(bus.mini_q_empty), 1);
    check("q_full_drained",  32'(bus.mini_q_full),  0);
    check("q_ovf_sticky",    32'(bus.mini_q_ovf),   1);
    step();

    // empty queue and zero-length readout
    do_read(0, 3, 1'b0);
    trig(0);
    @(negedge clock);
    check("z_not_empty", 32'(bus.mini_q_empty), 0);
    step();
    do_read(0, 0, 1'b1);
    @(negedge clock);
    check("z_popped", 32'(bus.mini_q_empty), 1);
    step();

    // parity: 3 errors on valid cycles, 2 on non-valid cycles
    do_reset();
    trig(0);
    step();
    bus.mini_rd_start = 1'b1;
    bus.mini_tbins    = 5'd5;
    for (int i = 0; i < 5; i++) exp_adr_q.push_back(11'(i));
    exp_done_q.push_back(cyc + 7);
    step();
    bus.mini_rd_start = 1'b0;
    step();
    bus.parity_err_mini = 2'b01;
    step();
    step();
    step();
    bus.parity_err_mini = 2'b00;
    step();
    step();
    bus.parity_err_mini = 2'b01;
    step();
    step();
    bus.parity_err_mini = 2'b00;
    @(negedge clock);
    check("par_cnt",  32'(bus.mini_perr_cnt), 32'(EXP_PCNT));
    check("par_perr", 32'(bus.mini_perr),     32'(EXP_PERR));
    step();

    // reset mid-readout aborts with no done pulse
    trig(0);
    step();
    bus.mini_rd_start = 1'b1;
    bus.mini_tbins    = 5'd10;
    for (int i = 0; i < 10; i++) exp_adr_q.push_back(11'(i));
    exp_done_q.push_back(cyc + 12);
    step();
    bus.mini_rd_start = 1'b0;
    step();
    step();
    global_reset = 1'b1;
    step();
    global_reset = 1'b0;
    exp_adr_q.delete();
    exp_done_q.delete();
    @(negedge clock);
    check("abort_busy",     32'(bus.mini_rd_busy),   0);
    check("abort_valid",    32'(bus.mini_rd_valid),  0);
    check("abort_empty",    32'(bus.mini_q_empty),   1);
    check("abort_perr",     32'(bus.mini_perr),      0);
    check("abort_perr_cnt", 32'(bus.mini_perr_cnt),  0);
    check("abort_radr",     32'(bus.fifo_radr_mini), 0);
    step();
    repeat (15) step();

    check("sb_addr_left", 32'(exp_adr_q.size()),  0);
    check("sb_done_left", 32'(exp_done_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
